// File: rtl/vc_test_source_arbiter.sv
// Round-robin val/rdy arbiter sharing one sink among p_nreqs test-source streams.
// Define VC_TEST_SOURCE_ARBITER_CNT_EN to add per-source saturating transfer counters (cnt).
module vc_test_source_arbiter #(
    parameter int unsigned p_nreqs     = 4,
    parameter int unsigned p_msg_nbits = 32,
    parameter int unsigned p_burst     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_nreqs-1:0]             in_val,
    output logic [p_nreqs-1:0]             in_rdy,
    input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
    input  logic [p_nreqs-1:0]             in_done,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_msg_nbits-1:0]         out_msg,
    output logic [$clog2(p_nreqs)-1:0]     out_src,
    output logic                           done
`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
    ,
    output logic [p_nreqs*16-1:0]          cnt
`endif
);

    localparam int unsigned SrcW  = $clog2(p_nreqs);
    localparam int unsigned CandW = SrcW + 1;
    localparam logic [CandW-1:0] NReqs   = CandW'(p_nreqs);
    localparam logic [SrcW-1:0]  LastIdx = SrcW'(p_nreqs - 1);
    localparam logic [7:0]       BurstLen = 8'(p_burst);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SrcW-1:0] grant_q, grant_d;
    logic [SrcW-1:0] prio_q, prio_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;

    logic [p_msg_nbits-1:0] msg_arr [p_nreqs];
    logic [CandW-1:0]       cand;
    logic                   pick_found;
    logic [SrcW-1:0]        pick_idx;
    logic                   grant_val;
    logic                   xfer;
    logic [SrcW-1:0]        next_prio;

    always_comb begin
        for (int i = 0; i < p_nreqs; i++) begin
            msg_arr[i] = in_msg[i*p_msg_nbits +: p_msg_nbits];
        end
    end

    // Scan from prio upward with wrap; the first hit wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < p_nreqs; k++) begin
            cand = {1'b0, prio_q} + CandW'(k);
            if (cand >= NReqs) begin
                cand = cand - NReqs;
            end
            if (!pick_found && in_val[cand[SrcW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[SrcW-1:0];
            end
        end
    end

    assign next_prio = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        burst_cnt_d = burst_cnt_q;
        grant_val   = 1'b0;
        xfer        = 1'b0;
        out_val     = 1'b0;
        out_msg     = '0;
        out_src     = '0;
        in_rdy      = '0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A pending request beats a simultaneous done from the same source.
                if (pick_found) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end else if (&in_done) begin
                    state_d = StDone;
                end
            end
            StGrant: begin
                grant_val       = in_val[grant_q];
                out_val         = grant_val;
                out_msg         = msg_arr[grant_q];
                out_src         = grant_q;
                in_rdy[grant_q] = out_rdy;
                xfer            = grant_val && out_rdy;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                if ((xfer && (burst_cnt_q + 8'd1 == BurstLen)) || !grant_val
                    || in_done[grant_q]) begin
                    state_d = StIdle;
                    prio_d  = next_prio;
                end
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            prio_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
    logic [15:0] cnt_q [p_nreqs];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_nreqs; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < p_nreqs; i++) begin
                if (xfer && (grant_q == SrcW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    // Counters absent; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_vc_test_source_arbiter.sv
// Directed bench for vc_test_source_arbiter: dut_a uses p_burst=1, dut_b uses p_burst=3.
module tb_vc_test_source_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [3:0]   a_in_val, a_in_rdy, a_in_done;
    logic [127:0] a_in_msg;
    logic         a_out_val, a_out_rdy, a_done;
    logic [31:0]  a_out_msg;
    logic [1:0]   a_out_src;

    logic [3:0]   b_in_val, b_in_rdy, b_in_done;
    logic [127:0] b_in_msg;
    logic         b_out_val, b_out_rdy, b_done;
    logic [31:0]  b_out_msg;
    logic [1:0]   b_out_src;

`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
    logic [63:0]  a_cnt, b_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vc_test_source_arbiter #(.p_nreqs(4), .p_msg_nbits(32), .p_burst(1)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .in_val  (a_in_val),
        .in_rdy  (a_in_rdy),
        .in_msg  (a_in_msg),
        .in_done (a_in_done),
        .out_val (a_out_val),
        .out_rdy (a_out_rdy),
        .out_msg (a_out_msg),
        .out_src (a_out_src),
        .done    (a_done)
`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
        ,
        .cnt     (a_cnt)
`endif
    );

    vc_test_source_arbiter #(.p_nreqs(4), .p_msg_nbits(32), .p_burst(3)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .in_val  (b_in_val),
        .in_rdy  (b_in_rdy),
        .in_msg  (b_in_msg),
        .in_done (b_in_done),
        .out_val (b_out_val),
        .out_rdy (b_out_rdy),
        .out_msg (b_out_msg),
        .out_src (b_out_src),
        .done    (b_done)
`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
        ,
        .cnt     (b_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sets inputs first; returns 1 time unit after release, before the first edge.
    task automatic release_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        a_in_val  = 4'hF;
        a_in_done = 4'hF;
        a_out_rdy = 1'b1;
        a_in_msg  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001};
        b_in_val  = 4'hF;
        b_in_done = 4'hF;
        b_out_rdy = 1'b1;
        b_in_msg  = a_in_msg;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (a_out_val !== 1'b0) begin
            n_err++; $display("FAIL reset_out_val: got %b expected 0", a_out_val);
        end
        n_vec++;
        if (a_in_rdy !== 4'h0) begin
            n_err++; $display("FAIL reset_in_rdy: got %h expected 0", a_in_rdy);
        end
        n_vec++;
        if (a_done !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b expected 0", a_done);
        end
        n_vec++;
        if (a_out_src !== 2'd0 || a_out_msg !== 32'h0) begin
            n_err++; $display("FAIL reset_src_msg: got %0d/%h expected 0/0", a_out_src, a_out_msg);
        end
        n_vec++;
        if (b_out_val !== 1'b0 || b_in_rdy !== 4'h0 || b_done !== 1'b0) begin
            n_err++; $display("FAIL reset_b: got val=%b rdy=%h done=%b expected 0/0/0",
                              b_out_val, b_in_rdy, b_done);
        end
    endtask

    task automatic test_round_robin();
        int src;
        a_in_val  = 4'hF;
        a_in_done = 4'h0;
        a_out_rdy = 1'b1;
        a_in_msg  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        release_reset();
        n_vec++;
        if (a_out_val !== 1'b0) begin
            n_err++; $display("FAIL rr_first_bubble: got %b expected 0", a_out_val);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            #1;
            if (k % 2 == 1) begin
                src = ((k - 1) / 2) % 4;
                n_vec++;
                if (a_out_val !== 1'b1 || a_out_src !== 2'(src)) begin
                    n_err++; $display("FAIL rr_grant c%0d: got val=%b src=%0d expected 1/%0d",
                                      k, a_out_val, a_out_src, src);
                end
                n_vec++;
                if (a_out_msg !== (32'hC0DE_0000 + 32'(src))) begin
                    n_err++; $display("FAIL rr_msg c%0d: got %h expected %h",
                                      k, a_out_msg, 32'hC0DE_0000 + 32'(src));
                end
                n_vec++;
                if (a_in_rdy !== (4'b0001 << src)) begin
                    n_err++; $display("FAIL rr_in_rdy c%0d: got %b expected %b",
                                      k, a_in_rdy, 4'b0001 << src);
                end
            end else begin
                n_vec++;
                if (a_out_val !== 1'b0) begin
                    n_err++; $display("FAIL rr_bubble c%0d: got %b expected 0", k, a_out_val);
                end
            end
        end
    endtask

    task automatic test_burst();
        int idx;
        logic        exp_val [9];
        logic [31:0] exp_msg [9];
        exp_val = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_msg = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'h0, 32'hA3, 32'hA4, 32'h0, 32'h0};
        idx       = 0;
        b_in_done = 4'h0;
        b_out_rdy = 1'b1;
        b_in_msg  = '0;
        b_in_val  = 4'b0100;
        b_in_msg[64 +: 32] = 32'hA0;
        release_reset();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                tick();
                b_in_val = (idx < 5) ? 4'b0100 : 4'b0000;
                b_in_msg[64 +: 32] = 32'hA0 + 32'(idx);
                #1;
            end
            n_vec++;
            if (b_out_val !== exp_val[c]) begin
                n_err++; $display("FAIL burst_val c%0d: got %b expected %b",
                                  c, b_out_val, exp_val[c]);
            end
            if (exp_val[c]) begin
                n_vec++;
                if (b_out_msg !== exp_msg[c] || b_out_src !== 2'd2) begin
                    n_err++; $display("FAIL burst_msg c%0d: got %h/%0d expected %h/2",
                                      c, b_out_msg, b_out_src, exp_msg[c]);
                end
            end
            if (b_in_val[2] && b_in_rdy[2]) idx++;
        end
        b_in_done = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            n_vec++;
            if (b_out_val !== 1'b0 || b_done !== 1'b0) begin
                n_err++; $display("FAIL burst_after_done c%0d: got val=%b done=%b expected 0/0",
                                  c, b_out_val, b_done);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_xfer;
        n_xfer    = 0;
        a_in_val  = 4'b0010;
        a_in_done = 4'h0;
        a_out_rdy = 1'b0;
        a_in_msg  = '0;
        a_in_msg[32 +: 32] = 32'hB1;
        release_reset();
        for (int c = 1; c <= 4; c++) begin
            tick();
            #1;
            n_vec++;
            if (a_out_val !== 1'b1 || a_out_src !== 2'd1 || a_out_msg !== 32'hB1
                || a_in_rdy !== 4'h0) begin
                n_err++; $display("FAIL bp_hold c%0d: got val=%b src=%0d msg=%h rdy=%b expected 1/1/b1/0000",
                                  c, a_out_val, a_out_src, a_out_msg, a_in_rdy);
            end
            if (a_out_val && a_out_rdy) n_xfer++;
        end
        tick();
        a_out_rdy = 1'b1;
        #1;
        n_vec++;
        if (a_out_val !== 1'b1 || a_in_rdy !== 4'b0010) begin
            n_err++; $display("FAIL bp_release: got val=%b rdy=%b expected 1/0010",
                              a_out_val, a_in_rdy);
        end
        if (a_out_val && a_out_rdy) n_xfer++;
        for (int c = 0; c < 2; c++) begin
            tick();
            a_in_val = 4'b0000;
            #1;
            if (a_out_val && a_out_rdy) n_xfer++;
        end
        n_vec++;
        if (n_xfer !== 1) begin
            n_err++; $display("FAIL bp_xfer_count: got %0d expected 1", n_xfer);
        end
    endtask

    task automatic test_done();
        a_in_val  = 4'h0;
        a_in_done = 4'hF;
        a_out_rdy = 1'b1;
        release_reset();
        n_vec++;
        if (a_done !== 1'b0) begin
            n_err++; $display("FAIL done_first_cycle: got %b expected 0", a_done);
        end
        tick();
        #1;
        n_vec++;
        if (a_done !== 1'b1) begin
            n_err++; $display("FAIL done_second_cycle: got %b expected 1", a_done);
        end
        a_in_val = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            n_vec++;
            if (a_out_val !== 1'b0 || a_in_rdy !== 4'h0 || a_done !== 1'b1) begin
                n_err++; $display("FAIL done_late_val c%0d: got val=%b rdy=%b done=%b expected 0/0/1",
                                  c, a_out_val, a_in_rdy, a_done);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        b_in_done = 4'h0;
        b_out_rdy = 1'b1;
        b_in_msg  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        b_in_val  = 4'b0100;
        release_reset();
        tick();
        #1;
        n_vec++;
        if (b_out_val !== 1'b1 || b_out_src !== 2'd2) begin
            n_err++; $display("FAIL mid_pre_grant2: got %b/%0d expected 1/2", b_out_val, b_out_src);
        end
        tick();
        b_in_val = 4'b0010;
        #1;
        tick();
        #1;
        tick();
        #1;
        n_vec++;
        if (b_out_val !== 1'b1 || b_out_src !== 2'd1 || b_out_msg !== 32'hC1) begin
            n_err++; $display("FAIL mid_grant1: got %b/%0d/%h expected 1/1/c1",
                              b_out_val, b_out_src, b_out_msg);
        end
        tick();
        #1;
        n_vec++;
        if (b_out_val !== 1'b1 || b_out_src !== 2'd1) begin
            n_err++; $display("FAIL mid_grant1_beat2: got %b/%0d expected 1/1", b_out_val, b_out_src);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (b_out_val !== 1'b0 || b_in_rdy !== 4'h0 || b_out_msg !== 32'h0) begin
            n_err++; $display("FAIL mid_async_drop: got val=%b rdy=%b msg=%h expected 0/0/0",
                              b_out_val, b_in_rdy, b_out_msg);
        end
        b_in_val = 4'b1001;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (b_out_val !== 1'b0) begin
            n_err++; $display("FAIL mid_post_bubble: got %b expected 0", b_out_val);
        end
        tick();
        #1;
        n_vec++;
        if (b_out_val !== 1'b1 || b_out_src !== 2'd0 || b_out_msg !== 32'hC0) begin
            n_err++; $display("FAIL mid_prio_reset: got %b/%0d/%h expected 1/0/c0",
                              b_out_val, b_out_src, b_out_msg);
        end
    endtask

`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
    task automatic test_counters();
        a_in_val  = 4'hF;
        a_in_done = 4'h0;
        a_out_rdy = 1'b1;
        a_in_msg  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        release_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (a_cnt[i*16 +: 16] !== 16'd5) begin
                n_err++; $display("FAIL cnt_field%0d: got %0d expected 5", i, a_cnt[i*16 +: 16]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_done();
        test_reset_mid_burst();
`ifdef VC_TEST_SOURCE_ARBITER_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vc_test_source_arbiter.md
Name: vc_test_source_arbiter

Overview:
Round-robin scheduler that shares one val/rdy message sink (a test sink or a DUT input port) among up to p_nreqs test-source streams.
- Each grant is locked to one requester for up to p_burst transfers, then rotates.
- Tags every forwarded message with its source index.
- Raises an aggregate done once every source reports done and the arbiter is idle.
- Sits between a bank of test sources and a single DUT/sink port in multi-stream test harnesses.

Parameters:
p_nreqs, 4, number of requesting streams (2..16)
p_msg_nbits, 32, message width in bits
p_burst, 1, maximum transfers per grant before forced rotation (1..255)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_val  input  p_nreqs  per-source valid
in_rdy  output  p_nreqs  per-source ready
in_msg  input  p_nreqs*p_msg_nbits  packed messages; source i occupies bits [i*p_msg_nbits +: p_msg_nbits]
in_done  input  p_nreqs  per-source done (sticky until reset)
out_val  output  1  sink valid
out_rdy  input  1  sink ready
out_msg  output  p_msg_nbits  forwarded message
out_src  output  $clog2(p_nreqs)  index of the source of out_msg
done  output  1  all sources done and arbiter idle

Behaviour:
Reset
- While reset==0: state=IDLE, grant=0, prio=0, burst_cnt=0.
- Outputs in reset: out_val=0, in_rdy=0, done=0, out_src=0, out_msg=0.

States: IDLE, GRANT, DONE.
- IDLE:
  - If any in_val: pick the first requester at or after prio, wrapping modulo p_nreqs. Register it as grant, clear burst_cnt, go to GRANT next cycle. This gives a 1-cycle arbitration bubble per grant.
  - Else if &in_done: go to DONE.
- GRANT:
  - out_val = in_val[grant]; out_msg = in_msg[grant]; out_src = grant.
  - in_rdy[grant] = out_rdy; all other in_rdy bits are 0. The data path is purely combinational, with zero added latency.
  - A transfer occurs when out_val && out_rdy; each transfer increments burst_cnt.
  - Release at the clock edge, returning to IDLE with prio = grant+1 (mod p_nreqs), if any of:
    - a transfer occurs and burst_cnt+1 == p_burst;
    - in_val[grant]==0 (source idle or finished);
    - in_done[grant]==1.
- DONE:
  - done=1, out_val=0, all in_rdy=0.
  - Stays in DONE until reset. Late in_val is ignored.

Rules and boundaries
- in_val is never combinationally dependent on in_rdy. Grant never changes while out_val=1 && out_rdy=0, so the message stays stable under backpressure.
- prio wraps p_nreqs-1 -> 0. A single active requester is re-granted every other cycle (grant, bubble).
- If in_val and in_done for the same source are both high in IDLE, in_val takes priority.
- Non-power-of-two p_nreqs: grant indices >= p_nreqs are never produced.
- Asynchronous reset mid-burst: outputs drop immediately, with no partial transfer; state returns to IDLE.

Optional Feature:
VC_TEST_SOURCE_ARBITER_CNT_EN
- Defined: adds output port cnt (p_nreqs*16 bits). Each 16-bit field counts completed transfers for its source, saturates at 16'hFFFF, and clears on reset.
- Undefined: port and counters are absent. Arbitration behaviour is identical.

Test Plan:
1. p_nreqs=4, p_burst=1, all in_val=1, out_rdy=1, after reset -> out_src sequence 0,1,2,3,0 with an idle cycle between grants; out_msg equals the matching in_msg slice.
2. p_burst=3, source 2 only, 5 msgs (0xA0..0xA4), out_rdy=1 -> A0,A1,A2 back-to-back, 1 bubble, then A3,A4; after in_done[2], state returns to IDLE.
3. Grant held, out_rdy=0 for 4 cycles -> out_val=1, out_msg/out_src constant, in_rdy[grant]=0; on out_rdy=1, exactly one transfer.
4. All in_done=1, in_val=0 -> done=1 on the second cycle; late in_val[1]=1 leaves out_val=0.
5. reset=0 asserted mid-burst at source 1 -> out_val=0 and in_rdy=0 in the same cycle; after release, the first grant goes to the lowest requesting index from prio=0.
6. With VC_TEST_SOURCE_ARBITER_CNT_EN, run test 1 for 20 transfers -> each cnt field equals 5.
